// File: rtl/pipe_gen.sv
// Scrolling pipe-column generator: blank spacing columns, then PIPE_W pipe columns with a random gap.
// Optional spawn counter enabled by defining PIPE_GEN_SCORE_EN.
module pipe_gen #(
  parameter int unsigned SCROLL_DIV = 25,
  parameter int unsigned SPACING    = 6,
  parameter int unsigned PIPE_W     = 2,
  parameter int unsigned GAP        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [9:0]  rnd,
  output logic [15:0] col_out,
  output logic        col_valid,
  output logic [3:0]  gap_top,
  output logic [7:0]  pipes_spawned
);

  localparam int unsigned DIV_W     = 10;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ROWS      = 16;
  localparam int unsigned GAP_RANGE = 15 - GAP;

  typedef enum logic [1:0] {IDLE, SPACE, PIPE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [CNT_W-1:0] col_cnt, cnt_nxt;
  logic [3:0]       gap_nxt;
  logic [15:0]      col_nxt;
  logic             valid_nxt;
  logic             spawn;
  logic [3:0]       rnd_lo;
  logic [3:0]       gap_new;
  logic             unused_rnd;

  assign unused_rnd = ^rnd[9:4];
  assign rnd_lo     = rnd[3:0];

  // Single conditional subtract is enough: rnd_lo < 2*GAP_RANGE for every legal GAP.
  always_comb begin
    if (rnd_lo >= 4'(GAP_RANGE)) gap_new = rnd_lo - 4'(GAP_RANGE) + 4'd1;
    else                         gap_new = rnd_lo + 4'd1;
  end

  function automatic logic [15:0] pipe_col(input logic [3:0] top);
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [15:0] col;
    lo = {1'b0, top};
    hi = lo + 5'(GAP);
    for (int r = 0; r < ROWS; r++) begin
      col[r] = !((5'(r) >= lo) && (5'(r) < hi));
    end
    return col;
  endfunction

  // Next-state, divider, column counter and registered-output values.
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    cnt_nxt   = col_cnt;
    gap_nxt   = gap_top;
    col_nxt   = col_out;
    valid_nxt = 1'b0;
    spawn     = 1'b0;
    if (run) begin
      case (state)
        IDLE: begin
          state_nxt = SPACE;
          div_nxt   = '0;
          cnt_nxt   = '0;
        end
        SPACE, PIPE: begin
          if (div == DIV_W'(SCROLL_DIV - 1)) begin
            div_nxt   = '0;
            valid_nxt = 1'b1;
            if (state == SPACE) begin
              if (col_cnt == CNT_W'(SPACING)) begin
                spawn     = 1'b1;
                gap_nxt   = gap_new;
                col_nxt   = pipe_col(gap_new);
                cnt_nxt   = '0;
                state_nxt = (PIPE_W > 1) ? PIPE : SPACE;
              end else begin
                col_nxt = '0;
                cnt_nxt = col_cnt + CNT_W'(1);
              end
            end else begin
              col_nxt = pipe_col(gap_top);
              if (col_cnt + CNT_W'(1) == CNT_W'(PIPE_W - 1)) begin
                state_nxt = SPACE;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = col_cnt + CNT_W'(1);
              end
            end
          end else begin
            div_nxt = div + DIV_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      col_cnt   <= '0;
      gap_top   <= '0;
      col_out   <= '0;
      col_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      col_cnt   <= cnt_nxt;
      gap_top   <= gap_nxt;
      col_out   <= col_nxt;
      col_valid <= valid_nxt;
    end
  end

`ifdef PIPE_GEN_SCORE_EN
  // Saturating count of pipe spawns.
  always_ff @(posedge clk) begin
    if (reset)                                pipes_spawned <= '0;
    else if (spawn && pipes_spawned != 8'hFF) pipes_spawned <= pipes_spawned + 8'd1;
  end
`else
  logic unused_spawn;
  assign unused_spawn  = spawn;
  assign pipes_spawned = 8'h00;
`endif

endmodule

// File: tb/tb_pipe_gen.sv
// Directed self-checking bench for pipe_gen with SCROLL_DIV=4, SPACING=6, PIPE_W=2, GAP=4.
module tb_pipe_gen;

  logic        clk;
  logic        reset;
  logic        run;
  logic [9:0]  rnd;
  logic [15:0] col_out;
  logic        col_valid;
  logic [3:0]  gap_top;
  logic [7:0]  pipes_spawned;

  int vectors;
  int miscompares;

  pipe_gen #(.SCROLL_DIV(4), .SPACING(6), .PIPE_W(2), .GAP(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .rnd          (rnd),
    .col_out      (col_out),
    .col_valid    (col_valid),
    .gap_top      (gap_top),
    .pipes_spawned(pipes_spawned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges; outputs are sampled 1ns after the last one.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rnd = 10'h3FF;
    do_reset();
    cycles(3);
    vectors++;
    if (col_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", col_valid); end
    vectors++;
    if (col_out !== 16'h0000) begin miscompares++; $display("FAIL reset_col got %h want 0000", col_out); end
    vectors++;
    if (gap_top !== 4'h0) begin miscompares++; $display("FAIL reset_gap got %h want 0", gap_top); end
    vectors++;
    if (pipes_spawned !== 8'h00) begin miscompares++; $display("FAIL reset_pipes got %h want 00", pipes_spawned); end
  endtask

  // Run 40 edges with rnd=0; pulses at edges 5,9,...; pulses 7-8 carry the pipe.
  task automatic test_sequence();
    logic [15:0] exp_col;
    logic        exp_valid;
    int          pulse;
    exp_col = 16'h0000;
    pulse   = 0;
    rnd     = 10'h000;
    do_reset();
    run = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      cycles(1);
      exp_valid = (e >= 5) && (((e - 5) % 4) == 0);
      if (exp_valid) begin
        pulse++;
        exp_col = (pulse == 7 || pulse == 8) ? 16'hFFE1 : 16'h0000;
      end
      vectors++;
      if (col_valid !== exp_valid) begin
        miscompares++;
        $display("FAIL seq_valid edge %0d got %b want %b", e, col_valid, exp_valid);
      end
      vectors++;
      if (col_out !== exp_col) begin
        miscompares++;
        $display("FAIL seq_col edge %0d got %h want %h", e, col_out, exp_col);
      end
    end
    vectors++;
    if (gap_top !== 4'd1) begin miscompares++; $display("FAIL seq_gap got %0d want 1", gap_top); end
  endtask

  task automatic test_rnd_change();
    rnd = 10'h00F;
    do_reset();
    run = 1'b1;
    cycles(29);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'hFE1F) begin
      miscompares++;
      $display("FAIL rnd_pipe1 got v=%b col=%h want v=1 col=fe1f", col_valid, col_out);
    end
    vectors++;
    if (gap_top !== 4'd5) begin miscompares++; $display("FAIL rnd_gap1 got %0d want 5", gap_top); end
    rnd = 10'h3F0;
    cycles(4);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'hFE1F) begin
      miscompares++;
      $display("FAIL rnd_pipe2 got v=%b col=%h want v=1 col=fe1f", col_valid, col_out);
    end
    vectors++;
    if (gap_top !== 4'd5) begin miscompares++; $display("FAIL rnd_gap2 got %0d want 5", gap_top); end
    cycles(4);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL rnd_blank got v=%b col=%h want v=1 col=0000", col_valid, col_out);
    end
  endtask

  // Freeze with div=2 just after the first pipe column.
  task automatic test_freeze();
    rnd = 10'h000;
    do_reset();
    run = 1'b1;
    cycles(31);
    run = 1'b0;
    rnd = 10'h00F;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      vectors++;
      if (col_valid !== 1'b0 || col_out !== 16'hFFE1 || gap_top !== 4'd1) begin
        miscompares++;
        $display("FAIL freeze_hold cyc %0d got v=%b col=%h gap=%0d want v=0 col=ffe1 gap=1",
                 i, col_valid, col_out, gap_top);
      end
    end
    run = 1'b1;
    cycles(1);
    vectors++;
    if (col_valid !== 1'b0) begin miscompares++; $display("FAIL freeze_early got %b want 0", col_valid); end
    cycles(1);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'hFFE1) begin
      miscompares++;
      $display("FAIL freeze_resume got v=%b col=%h want v=1 col=ffe1", col_valid, col_out);
    end
    cycles(4);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL freeze_next got v=%b col=%h want v=1 col=0000", col_valid, col_out);
    end
  endtask

  // Reset coincident with the first pipe step, then confirm a fresh start from IDLE.
  task automatic test_reset_mid();
    rnd = 10'h000;
    do_reset();
    run = 1'b1;
    cycles(28);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    vectors++;
    if (col_valid !== 1'b0 || col_out !== 16'h0000 || gap_top !== 4'h0 || pipes_spawned !== 8'h00) begin
      miscompares++;
      $display("FAIL midreset got v=%b col=%h gap=%h pipes=%h want all zero",
               col_valid, col_out, gap_top, pipes_spawned);
    end
    for (int i = 1; i <= 4; i++) begin
      cycles(1);
      vectors++;
      if (col_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_idle edge %0d got %b want 0", i, col_valid);
      end
    end
    cycles(1);
    vectors++;
    if (col_valid !== 1'b1 || col_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL midreset_restart got v=%b col=%h want v=1 col=0000", col_valid, col_out);
    end
  endtask

  task automatic test_score();
    logic [7:0] exp_one;
    logic [7:0] exp_sat;
`ifdef PIPE_GEN_SCORE_EN
    exp_one = 8'h01;
    exp_sat = 8'hFF;
`else
    exp_one = 8'h00;
    exp_sat = 8'h00;
`endif
    rnd = 10'h005;
    do_reset();
    run = 1'b1;
    cycles(29);
    vectors++;
    if (pipes_spawned !== exp_one) begin
      miscompares++;
      $display("FAIL score_first got %h want %h", pipes_spawned, exp_one);
    end
    cycles(32 * 300);
    vectors++;
    if (pipes_spawned !== exp_sat) begin
      miscompares++;
      $display("FAIL score_sat got %h want %h", pipes_spawned, exp_sat);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    run         = 1'b0;
    rnd         = '0;
    test_reset();
    test_sequence();
    test_rnd_change();
    test_freeze();
    test_reset_mid();
    test_score();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_gen.md
PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 SHALL provide parameter SCROLL_DIV, default 25: clock cycles per scroll step (legal 2..1023).
REQ-002 SHALL provide parameter SPACING, default 6: blank columns emitted between pipes (legal 1..15).
REQ-003 SHALL provide parameter PIPE_W, default 2: columns per pipe (legal 1..4).
REQ-004 SHALL provide parameter GAP, default 4: gap height in rows (legal 2..7).
REQ-005 SHALL have one clock and a synchronous, active-high reset: `clk  in  1  system clock`, then `reset  in  1  synchronous active-high reset`.
REQ-006 `run  in  1` -- 1 = game active; 0 = freeze all state.
REQ-007 `rnd  in  10` -- pseudo-random word from the upstream LFSR; only rnd[3:0] is used.
REQ-008 `col_out  out  16` -- row pattern of the column entering at the right edge; bit r = row r; 1 = pipe pixel.
REQ-009 `col_valid  out  1` -- one-cycle pulse per scroll step, qualifying col_out.
REQ-010 `gap_top  out  4` -- top row of the current or most recent gap.
REQ-011 `pipes_spawned  out  8` -- count of pipes spawned (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, SPACE and PIPE.
REQ-013 IDLE with run=1 SHALL move to SPACE at the next edge, with div=0 and col_cnt=0; no step occurs in that cycle.
REQ-014 In SPACE or PIPE, div SHALL increment every cycle with run=1.
REQ-015 When div==SCROLL_DIV-1 with run=1, div SHALL wrap to 0 and a step SHALL occur.
REQ-016 Each step SHALL register col_out and assert col_valid at the same edge; col_out SHALL hold between steps; col_valid SHALL be 0 on all non-step cycles.
REQ-017 A SPACE step SHALL emit col_out=0 and increment col_cnt.
REQ-018 The step that makes col_cnt reach SPACING SHALL instead be the first PIPE step: state goes to PIPE, col_cnt resets, and gap_top is sampled from rnd in that same cycle.
REQ-019 gap_top SHALL equal 1 + (rnd[3:0] mod (15-GAP)), computed as a single conditional subtract of (15-GAP), and SHALL be held until the next pipe spawn.
REQ-020 A PIPE step SHALL emit col_out[r]=0 for gap_top <= r < gap_top+GAP and col_out[r]=1 otherwise.
REQ-021 PIPE SHALL emit exactly PIPE_W identical columns, then return to SPACE; the next step is blank.
REQ-022 With run=0 in any state: state, div, col_cnt, gap_top and col_out SHALL hold, and col_valid SHALL be 0.
REQ-023 After run returns to 1, counting SHALL resume from the held div value, with no extra or lost step.
REQ-024 There SHALL be no transition back to IDLE other than reset.
REQ-025 rnd SHALL be sampled only at a pipe-spawn step; changes to rnd at any other time SHALL have no effect.

Reset
REQ-026 With reset=1 at a clock edge: state=IDLE, div=0, col_cnt=0, col_out=16'h0000, col_valid=0, gap_top=4'h0, pipes_spawned=8'h00.
REQ-027 Reset SHALL take priority over run and over a coincident step, including mid-PIPE; no col_valid pulse SHALL occur in the cycle after reset.

Configuration
REQ-028 With macro PIPE_GEN_SCORE_EN defined, pipes_spawned SHALL increment at each pipe-spawn step (REQ-018) and saturate at 8'hFF.
REQ-029 Without PIPE_GEN_SCORE_EN, no counter logic SHALL be built and pipes_spawned SHALL be constant 8'h00; the port SHALL exist in both builds.

Verification (SCROLL_DIV=4, SPACING=6, PIPE_W=2, GAP=4 unless stated)
REQ-030 Reset, then run=1 held -> col_valid pulses every 4 cycles; the first pulse comes 5 edges after run is first sampled; pulses 1-6 carry col_out=0, pulses 7-8 carry the pipe pattern, pulse 9 carries 0.
REQ-031 rnd[3:0]=4'h0 at the spawn step -> gap_top=1, col_out=16'hFFE1 on both pipe pulses.
REQ-032 rnd[3:0]=4'hF at the spawn step, changed to 4'h0 during the second pipe column -> gap_top=5 and col_out=16'hFE1F on both pipe pulses.
REQ-033 run dropped for 10 cycles with div=2 -> no col_valid and all outputs held; the next pulse comes 2 cycles after run returns.
REQ-034 reset pulsed in the cycle of the first pipe step -> the following cycle shows col_valid=0, col_out=0, gap_top=0, pipes_spawned=0, state IDLE.
REQ-035 With PIPE_GEN_SCORE_EN, 300 pipes spawned -> pipes_spawned=8'hFF; without the macro, pipes_spawned=0 throughout.
